// File: rtl/ftdi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_pkg
// Description : Shared types and constants for the FTDI transmit arbiter.
//               - ftdi_state_e : arbiter sequencing states
//               - HDR_WAIT_*   : meaning of the WAIT_LOW sub-flag (which byte
//                                the controller is finishing)
//               - TAG_NIBBLE   : upper nibble of the channel header byte
//               - DEFAULT_TX_TIMEOUT : default SEND/HDR strobe timeout
// Options     : FTDI_ARB_TAG_EN (header bytes) is consumed by ftdi_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ftdi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR      = 2'd1,
        ST_SEND     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } ftdi_state_e;

    // Sub-flag qualifying WAIT_LOW: after a header the arbiter must continue
    // with the data byte instead of returning to IDLE.
    localparam logic HDR_WAIT_DATA = 1'b0;
    localparam logic HDR_WAIT_HDR  = 1'b1;

    localparam logic [3:0] TAG_NIBBLE         = 4'hA;
    localparam int         DEFAULT_TX_TIMEOUT = 1024;

    // Header byte announcing which channel the following data byte belongs to.
    function automatic logic [7:0] tag_byte(input logic [3:0] ch);
        return {TAG_NIBBLE, ch};
    endfunction

endpackage : ftdi_pkg
`default_nettype wire

// File: rtl/ftdi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_rr_pick
// Description : Combinational round-robin search. Finds the first set bit of
//               in_valid starting at in_ptr+1 and wrapping around, so the
//               channel that was served last has the lowest priority.
// Ports       : in_valid  [NUM_CH] request vector
//               in_ptr    [CH_W]   last served channel
//               out_grant [NUM_CH] one-hot winner (all zero if none)
//               out_idx   [CH_W]   index of the winner
//               out_any            at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_rr_pick
    import ftdi_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] in_valid,
    input  logic [CH_W-1:0]   in_ptr,
    output logic [NUM_CH-1:0] out_grant,
    output logic [CH_W-1:0]   out_idx,
    output logic              out_any
);

    logic [CH_W-1:0] cand;

    always_comb begin
        out_grant = '0;
        out_idx   = '0;
        out_any   = 1'b0;
        cand      = '0;
        // Offsets 1..NUM_CH: offset NUM_CH revisits in_ptr itself last.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(in_ptr) + k) % NUM_CH);
            if (!out_any && in_valid[cand]) begin
                out_any = 1'b1;
                out_idx = cand;
            end
        end
        out_grant[out_idx] = out_any;
    end

endmodule : ftdi_rr_pick
`default_nettype wire

// File: rtl/ftdi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_tx_arbiter
// Description : Shares the FTDI controller's ctrl_data/ctrl_data_rdy input
//               between NUM_CH byte producers with round-robin arbitration.
//               One byte is held at a time; completion is detected from the
//               controller's FTDI write strobe (rising edge), after which the
//               arbiter waits for the strobe to fall before releasing.
// Ports       : in_clk, in_rst_n (async, active-low)
//               in_req_valid[NUM_CH], in_req_data[NUM_CH*8] -> producers
//               out_req_ready[NUM_CH]  one-hot accept pulse (same cycle)
//               out_ctrl_data[8], out_ctrl_data_rdy -> FTDI controller
//               in_ftdi_wr            monitored controller write strobe
//               out_busy, out_grant_ch[CH_W], out_timeout  status
// Options     : `define FTDI_ARB_TAG_EN to send a header byte {A, ch} before
//               the data byte whenever the channel changes.
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_tx_arbiter
    import ftdi_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int TX_TIMEOUT = DEFAULT_TX_TIMEOUT
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic [NUM_CH-1:0]   in_req_valid,
    input  logic [NUM_CH*8-1:0] in_req_data,
    output logic [NUM_CH-1:0]   out_req_ready,
    output logic [7:0]          out_ctrl_data,
    output logic                out_ctrl_data_rdy,
    input  logic                in_ftdi_wr,
    output logic                out_busy,
    output logic [CH_W-1:0]     out_grant_ch,
    output logic                out_timeout
);

    // Counter only needs to reach TX_TIMEOUT-1.
    localparam int CNT_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [CH_W-1:0] PTR_RST = CH_W'(NUM_CH - 1);

    ftdi_state_e       state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_prev_q;

`ifdef FTDI_ARB_TAG_EN
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic              last_vld_q, last_vld_d;
    logic              hdr_wait_q, hdr_wait_d;
`endif

    logic [NUM_CH-1:0] pick_grant;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic [NUM_CH-1:0] ready_c;
    logic              rdy_c;
    logic              timeout_c;
    logic              wr_rise;
    logic              timeout_hit;

    ftdi_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .in_valid  (in_req_valid),
        .in_ptr    (ptr_q),
        .out_grant (pick_grant),
        .out_idx   (pick_idx),
        .out_any   (pick_any)
    );

    // wr_prev_q tracks the strobe in every state, so a strobe that is already
    // high when SEND/HDR is entered never counts as an edge.
    assign wr_rise     = in_ftdi_wr & ~wr_prev_q;
    assign timeout_hit = (TX_TIMEOUT != 0) && (cnt_q == CNT_W'(TX_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        grant_ch_d = grant_ch_q;
        ptr_d      = ptr_q;
        cnt_d      = '0;
        ready_c    = '0;
        rdy_c      = 1'b0;
        timeout_c  = 1'b0;
`ifdef FTDI_ARB_TAG_EN
        last_ch_d  = last_ch_q;
        last_vld_d = last_vld_q;
        hdr_wait_d = hdr_wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    ready_c    = pick_grant;
                    hold_d     = in_req_data[{pick_idx, 3'b000} +: 8];
                    grant_ch_d = pick_idx;
                    ptr_d      = pick_idx;
                    state_d    = ST_SEND;
`ifdef FTDI_ARB_TAG_EN
                    if (!last_vld_q || (last_ch_q != pick_idx)) begin
                        state_d    = ST_HDR;
                        hdr_wait_d = HDR_WAIT_HDR;
                    end
`endif
                end
            end
            ST_HDR, ST_SEND: begin
                rdy_c = 1'b1;
                if (wr_rise) begin
                    // Leave before the controller returns to ready, otherwise
                    // it would transmit the same byte again.
                    state_d = ST_WAIT_LOW;
                end else if (timeout_hit) begin
                    timeout_c = 1'b1;
                    state_d   = ST_IDLE;
`ifdef FTDI_ARB_TAG_EN
                    hdr_wait_d = HDR_WAIT_DATA;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                if (!in_ftdi_wr) begin
                    state_d = ST_IDLE;
`ifdef FTDI_ARB_TAG_EN
                    if (hdr_wait_q == HDR_WAIT_HDR) begin
                        state_d    = ST_SEND;
                        hdr_wait_d = HDR_WAIT_DATA;
                    end else begin
                        last_ch_d  = grant_ch_q;
                        last_vld_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            grant_ch_q <= '0;
            ptr_q      <= PTR_RST;
            cnt_q      <= '0;
            wr_prev_q  <= 1'b0;
`ifdef FTDI_ARB_TAG_EN
            last_ch_q  <= '0;
            last_vld_q <= 1'b0;
            hdr_wait_q <= HDR_WAIT_DATA;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            grant_ch_q <= grant_ch_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            wr_prev_q  <= in_ftdi_wr;
`ifdef FTDI_ARB_TAG_EN
            last_ch_q  <= last_ch_d;
            last_vld_q <= last_vld_d;
            hdr_wait_q <= hdr_wait_d;
`endif
        end
    end

    // The accept pulse is combinational from the valids; masking it with the
    // reset keeps a producer from believing a byte was taken during reset.
    assign out_req_ready     = ready_c & {NUM_CH{in_rst_n}};
    assign out_ctrl_data_rdy = rdy_c;
    assign out_timeout       = timeout_c;
    assign out_busy          = (state_q != ST_IDLE);
    assign out_grant_ch      = grant_ch_q;

`ifdef FTDI_ARB_TAG_EN
    assign out_ctrl_data = (hdr_wait_q == HDR_WAIT_HDR) ? tag_byte(4'(grant_ch_q)) : hold_q;
`else
    assign out_ctrl_data = hold_q;
`endif

endmodule : ftdi_tx_arbiter
`default_nettype wire

// File: tb/tb_ftdi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ftdi_tx_arbiter
// Description : Self-checking bench for ftdi_tx_arbiter (NUM_CH=4,
//               TX_TIMEOUT=16). A controller model raises the write strobe
//               3 cycles after data-ready and holds it for 5 cycles, logging
//               the byte on each rise. Build with FTDI_ARB_TAG_EN to run the
//               header-byte sequences instead of the raw-byte ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [7:0]  ctrl_data;
    logic        rdy;
    logic        wr;
    logic        busy;
    logic [1:0]  grant;
    logic        timeout;

    int          checks   = 0;
    int          failures = 0;
    logic        strobe_en = 1'b0;
    logic        auto_data = 1'b1;
    int          sent [4];
    int          acc_cnt [4];
    logic [7:0]  wire_log [$];

    typedef struct {
        logic [3:0] valid;
        logic [1:0] ch;
        logic [7:0] byt;
    } vec_t;
    vec_t tbl [13];

    ftdi_tx_arbiter #(
        .NUM_CH     (4),
        .CH_W       (2),
        .TX_TIMEOUT (16)
    ) dut (
        .in_clk            (clk),
        .in_rst_n          (rst_n),
        .in_req_valid      (valid),
        .in_req_data       (data),
        .out_req_ready     (ready),
        .out_ctrl_data     (ctrl_data),
        .out_ctrl_data_rdy (rdy),
        .in_ftdi_wr        (wr),
        .out_busy          (busy),
        .out_grant_ch      (grant),
        .out_timeout       (timeout)
    );

    always #5 clk = ~clk;

    // Controller model: strobe 3 cycles after it sees data-ready.
    initial begin
        wr = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (strobe_en && rdy && !wr) begin
                repeat (3) @(posedge clk);
                #1;
                if (strobe_en) begin
                    wr = 1'b1;
                    wire_log.push_back(ctrl_data);
                    repeat (5) @(posedge clk);
                    #1;
                    wr = 1'b0;
                end
            end
        end
    end

    // Accepted-byte counter per channel (valid & ready seen mid-cycle).
    initial begin
        for (int c = 0; c < 4; c++) acc_cnt[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++)
                if (valid[c] && ready[c]) acc_cnt[c] = acc_cnt[c] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        for (int c = 0; c < 4; c++) data[c*8 +: 8] = {4'(c + 1), 4'(sent[c])};
    endtask

    // Waits (bounded) for an accept pulse, checks it, then lets the clock
    // edge take the byte and advances that producer's next byte.
    task automatic wait_ready(input string nm, input logic [3:0] exp);
        int n = 0;
        #1;
        while (ready == 4'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, ready, exp);
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) if (exp[c]) sent[c] = sent[c] + 1;
        if (auto_data) refresh();
    endtask

    task automatic wait_wr(input string nm, input logic lvl);
        int n = 0;
        while (wr !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, wr, lvl);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

`ifdef FTDI_ARB_TAG_EN
    task automatic send_one(input int ch, input logic [7:0] b);
        data[ch*8 +: 8] = b;
        valid = 4'b0001 << ch;
        wait_ready("tag_ready", 4'b0001 << ch);
        valid = 4'b0;
        wait_idle("tag_idle");
    endtask
`endif

    initial begin
        int base;
        int tk;
        int tcount;
        logic [7:0] exp_tag [8];

        tbl[0]  = '{4'hF, 2'd0, 8'h10};
        tbl[1]  = '{4'hF, 2'd1, 8'h20};
        tbl[2]  = '{4'hF, 2'd2, 8'h30};
        tbl[3]  = '{4'hF, 2'd3, 8'h40};
        tbl[4]  = '{4'hF, 2'd0, 8'h11};
        tbl[5]  = '{4'hF, 2'd1, 8'h21};
        tbl[6]  = '{4'hF, 2'd2, 8'h31};
        tbl[7]  = '{4'hF, 2'd3, 8'h41};
        tbl[8]  = '{4'hA, 2'd1, 8'h22};
        tbl[9]  = '{4'hA, 2'd3, 8'h42};
        tbl[10] = '{4'h1, 2'd0, 8'h12};
        tbl[11] = '{4'h6, 2'd1, 8'h23};
        tbl[12] = '{4'h6, 2'd2, 8'h32};
        exp_tag = '{8'hA1, 8'h11, 8'h22, 8'hA3, 8'h33, 8'hA2, 8'h55, 8'h66};

        rst_n = 1'b0;
        valid = 4'b0;
        data  = 32'h0;
        for (int c = 0; c < 4; c++) sent[c] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 4'b0);
        chk("rst_ctrl_data", ctrl_data, 8'h00);
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 2'd0);
        chk("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;

`ifndef FTDI_ARB_TAG_EN
        // ---- single request on ch2 ----
        strobe_en = 1'b1;
        auto_data = 1'b0;
        @(posedge clk); #1;
        data[23:16] = 8'h5A;
        valid = 4'b0100;
        wait_ready("t1_ready", 4'b0100);
        valid = 4'b0;
        wait_wr("t1_wr_rise", 1'b1);
        chk("t1_rdy_at_rise", rdy, 1'b1);
        chk("t1_data", ctrl_data, 8'h5A);
        chk("t1_grant", grant, 2'd2);
        @(negedge clk);
        chk("t1_rdy_drop", rdy, 1'b0);
        chk("t1_busy_wait_low", busy, 1'b1);
        wait_wr("t1_wr_fall", 1'b0);
        chk("t1_busy_until_fall", busy, 1'b1);
        @(negedge clk);
        chk("t1_busy_clear", busy, 1'b0);
        chk("t1_ready_once", acc_cnt[2], 1);
        chk("t1_one_strobe", wire_log.size(), 1);

        // ---- round-robin table, fresh pointer ----
        do_reset();
        for (int c = 0; c < 4; c++) sent[c] = 0;
        auto_data = 1'b1;
        refresh();
        base = wire_log.size();
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            valid = tbl[i].valid;
            wait_ready($sformatf("rr_ready_%0d", i), 4'b0001 << tbl[i].ch);
            wait_wr($sformatf("rr_wr_%0d", i), 1'b1);
            chk($sformatf("rr_data_%0d", i), ctrl_data, tbl[i].byt);
            chk($sformatf("rr_grant_%0d", i), grant, tbl[i].ch);
            wait_idle($sformatf("rr_idle_%0d", i));
        end
        valid = 4'b0;
        chk("rr_strobe_count", wire_log.size() - base, 13);
        for (int i = 0; i < 13; i++)
            if (base + i < wire_log.size())
                chk($sformatf("rr_log_%0d", i), wire_log[base + i], tbl[i].byt);

        // ---- timeout: strobe withheld ----
        strobe_en = 1'b0;
        base = wire_log.size();
        @(posedge clk); #1;
        valid = 4'b0100;
        wait_ready("to_ready", 4'b0100);
        valid = 4'b0;
        tk = 0;
        tcount = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("to_data", ctrl_data, 8'h33);
                chk("to_rdy", rdy, 1'b1);
            end
            if (timeout) begin
                tcount++;
                if (tk == 0) tk = k;
            end
        end
        chk("to_cycle", tk, 16);
        chk("to_single_pulse", tcount, 1);
        chk("to_idle", busy, 1'b0);
        chk("to_no_strobe", wire_log.size() - base, 0);

        strobe_en = 1'b1;
        @(posedge clk); #1;
        valid = 4'b0010;
        wait_ready("after_to_ready", 4'b0010);
        valid = 4'b0;
        wait_wr("after_to_wr", 1'b1);
        chk("after_to_data", ctrl_data, 8'h24);
        wait_idle("after_to_idle");

        // ---- reset during SEND while ch1 waits ----
        strobe_en = 1'b0;
        @(posedge clk); #1;
        valid = 4'b0001;
        wait_ready("rst_t_ready0", 4'b0001);
        valid = 4'b0010;
        repeat (2) @(negedge clk);
        chk("rst_t_rdy_before", rdy, 1'b1);
        #2;
        rst_n = 1'b0;
        valid = 4'b0;
        #1;
        chk("rst_t_rdy", rdy, 1'b0);
        chk("rst_t_busy", busy, 1'b0);
        chk("rst_t_ready", ready, 4'b0);
        chk("rst_t_grant", grant, 2'd0);
        chk("rst_t_data", ctrl_data, 8'h00);
        chk("rst_t_timeout", timeout, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        valid = 4'b0011;
        wait_ready("rst_t_ch0_wins", 4'b0001);
        valid = 4'b0;
        strobe_en = 1'b1;
        wait_wr("rst_t_wr", 1'b1);
        chk("rst_t_data_after", ctrl_data, 8'h14);
        wait_idle("rst_t_idle");
`else
        // ---- header bytes on channel change ----
        strobe_en = 1'b1;
        auto_data = 1'b0;
        base = wire_log.size();
        @(posedge clk); #1;
        send_one(1, 8'h11);
        send_one(1, 8'h22);
        send_one(3, 8'h33);
        chk("tag_count1", wire_log.size() - base, 5);

        // ---- timeout in HDR ----
        strobe_en = 1'b0;
        data[23:16] = 8'h44;
        valid = 4'b0100;
        wait_ready("tag_to_ready", 4'b0100);
        valid = 4'b0;
        tk = 0;
        tcount = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("tag_to_hdr_byte", ctrl_data, 8'hA2);
            if (timeout) begin
                tcount++;
                if (tk == 0) tk = k;
            end
        end
        chk("tag_to_cycle", tk, 16);
        chk("tag_to_single", tcount, 1);
        chk("tag_to_idle", busy, 1'b0);
        chk("tag_to_nothing", wire_log.size() - base, 5);
        strobe_en = 1'b1;
        send_one(2, 8'h55);
        send_one(2, 8'h66);
        chk("tag_count2", wire_log.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < wire_log.size())
                chk($sformatf("tag_log_%0d", i), wire_log[base + i], exp_tag[i]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute safety bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule : tb_ftdi_tx_arbiter
`default_nettype wire
